// File: rtl/tl_l1_adapter.sv
// L1 request to single-beat TileLink-UL A/D channel adapter, one transaction in flight.
// Optional D-wait timeout enabled by defining TL_ADAPTER_TIMEOUT_EN.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_l1_adapter #(
  parameter int ADDR_BITS      = `TL_ADDR_BITS,
  parameter int SIZE_BITS      = `TL_SIZE_BITS,
  parameter int SOURCE_BITS    = `TL_SOURCE_BITS,
  parameter int DATA_BYTES     = `TL_DATA_BYTES,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_transaction,
  input  logic [1:0]               transaction_type,
  input  logic [ADDR_BITS-1:0]     address,
  input  logic [SIZE_BITS-1:0]     size,
  input  logic [SOURCE_BITS-1:0]   source,
  input  logic [DATA_BYTES*8-1:0]  write_data,
  input  logic [DATA_BYTES-1:0]    write_mask,
  output logic [DATA_BYTES*8-1:0]  read_data,
  output logic                     transaction_done,
  output logic                     busy,
  output logic                     error,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [2:0]               a_opcode,
  output logic [2:0]               a_param,
  output logic [SIZE_BITS-1:0]     a_size,
  output logic [SOURCE_BITS-1:0]   a_source,
  output logic [ADDR_BITS-1:0]     a_address,
  output logic [DATA_BYTES-1:0]    a_mask,
  output logic [DATA_BYTES*8-1:0]  a_data,
  input  logic                     d_valid,
  output logic                     d_ready,
  input  logic [2:0]               d_opcode,
  input  logic [SOURCE_BITS-1:0]   d_source,
  input  logic [DATA_BYTES*8-1:0]  d_data,
  input  logic                     d_denied,
  input  logic                     d_corrupt
);

  localparam int OFF_BITS = $clog2(DATA_BYTES);
  localparam int DATA_W   = DATA_BYTES * 8;

  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUTFULL  = 3'd0;
  localparam logic [2:0] OP_PUTPART  = 3'd1;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACKDATA   = 3'd1;

  localparam logic [1:0] T_GET       = 2'd0;
  localparam logic [1:0] T_PUTFULL   = 2'd1;
  localparam logic [1:0] T_PUTPART   = 2'd2;
  localparam logic [1:0] T_ILLEGAL   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_A_REQ  = 2'd1,
    S_D_WAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]              r_a_opcode;
  logic [SIZE_BITS-1:0]    r_a_size;
  logic [SOURCE_BITS-1:0]  r_a_source;
  logic [ADDR_BITS-1:0]    r_a_address;
  logic [DATA_BYTES-1:0]   r_a_mask;
  logic [DATA_W-1:0]       r_a_data;
  logic [DATA_W-1:0]       r_read_data;
  logic                    r_error;

  logic                    w_accept;
  logic                    w_legal;
  logic                    w_a_fire;
  logic                    w_d_fire;
  logic                    w_d_err;
  logic                    w_timeout;
  logic [2:0]              w_exp_d_op;
  logic [DATA_BYTES-1:0]   w_size_mask;

  // A byte lane is enabled when it falls in the same 2^size-aligned chunk as the address offset.
  function automatic logic [DATA_BYTES-1:0] size_mask(
    input logic [OFF_BITS-1:0]  off,
    input logic [SIZE_BITS-1:0] sz
  );
    logic [DATA_BYTES-1:0] m;
    int unsigned s;
    m = '0;
    s = 32'(sz);
    if (s > OFF_BITS) s = OFF_BITS;
    for (int b = 0; b < DATA_BYTES; b++) begin
      m[b] = ((unsigned'(b) >> s) == (32'(off) >> s));
    end
    return m;
  endfunction

  function automatic logic [2:0] a_op_of(input logic [1:0] t);
    logic [2:0] op;
    case (t)
      T_GET:     op = OP_GET;
      T_PUTFULL: op = OP_PUTFULL;
      T_PUTPART: op = OP_PUTPART;
      default:   op = OP_GET;
    endcase
    return op;
  endfunction

  assign w_legal     = (transaction_type != T_ILLEGAL) && (32'(size) <= OFF_BITS);
  assign w_accept    = (r_state == S_IDLE) && start_transaction;
  assign w_a_fire    = (r_state == S_A_REQ) && a_ready;
  assign w_d_fire    = (r_state == S_D_WAIT) && d_valid;
  assign w_size_mask = size_mask(address[OFF_BITS-1:0], size);
  assign w_exp_d_op  = (r_a_opcode == OP_GET) ? D_ACKDATA : D_ACK;
  assign w_d_err     = (d_opcode != w_exp_d_op) || (d_source != r_a_source) ||
                       d_denied || d_corrupt;

`ifdef TL_ADAPTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Reaching the limit on this edge means TIMEOUT_CYCLES D_WAIT cycles have elapsed.
  assign w_timeout = (r_state == S_D_WAIT) && !d_valid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_a_fire) begin
      r_cnt <= '0;
    end else if (r_state == S_D_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_transaction) w_next = w_legal ? S_A_REQ : S_DONE;
      end
      S_A_REQ: begin
        if (a_ready) w_next = S_D_WAIT;
      end
      S_D_WAIT: begin
        if (d_valid || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Handshake controls decode straight from the state register so reset drops them at once.
  always_comb begin
    a_valid          = 1'b0;
    d_ready          = 1'b0;
    busy             = 1'b0;
    transaction_done = 1'b0;
    case (r_state)
      S_A_REQ: begin
        a_valid = 1'b1;
        busy    = 1'b1;
      end
      S_D_WAIT: begin
        d_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        transaction_done = 1'b1;
        busy             = 1'b1;
      end
      default: begin
        a_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_opcode  <= '0;
      r_a_size    <= '0;
      r_a_source  <= '0;
      r_a_address <= '0;
      r_a_mask    <= '0;
      r_a_data    <= '0;
      r_read_data <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_opcode  <= a_op_of(transaction_type);
        r_a_size    <= size;
        r_a_source  <= source;
        r_a_address <= address;
        r_a_mask    <= (transaction_type == T_PUTPART) ? (write_mask & w_size_mask)
                                                       : w_size_mask;
        r_a_data    <= (transaction_type == T_GET) ? '0 : write_data;
        if (!w_legal) r_error <= 1'b1;
      end
      if (w_d_fire) begin
        r_error <= w_d_err;
        if (d_opcode == D_ACKDATA) r_read_data <= d_data;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign a_opcode  = r_a_opcode;
  assign a_param   = 3'd0;
  assign a_size    = r_a_size;
  assign a_source  = r_a_source;
  assign a_address = r_a_address;
  assign a_mask    = r_a_mask;
  assign a_data    = r_a_data;
  assign read_data = r_read_data;
  assign error     = r_error;

endmodule

// File: tb/tb_tl_l1_adapter.sv
// Directed bench for tl_l1_adapter: encoding, latency, stalls, error responses and reset abort.
// Define TL_ADAPTER_TIMEOUT_EN for both files to exercise the D-wait timeout.

module tb_tl_l1_adapter;
  localparam int AW = 32;
  localparam int SW = 3;
  localparam int IW = 4;
  localparam int DB = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_transaction;
  logic [1:0]    transaction_type;
  logic [AW-1:0] address;
  logic [SW-1:0] size;
  logic [IW-1:0] source;
  logic [DW-1:0] write_data;
  logic [DB-1:0] write_mask;
  logic [DW-1:0] read_data;
  logic          transaction_done;
  logic          busy;
  logic          error;
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_param;
  logic [SW-1:0] a_size;
  logic [IW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [DB-1:0] a_mask;
  logic [DW-1:0] a_data;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [IW-1:0] d_source;
  logic [DW-1:0] d_data;
  logic          d_denied;
  logic          d_corrupt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tl_l1_adapter #(
    .ADDR_BITS(AW), .SIZE_BITS(SW), .SOURCE_BITS(IW), .DATA_BYTES(DB), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start_transaction(start_transaction),
    .transaction_type(transaction_type), .address(address), .size(size), .source(source),
    .write_data(write_data), .write_mask(write_mask), .read_data(read_data),
    .transaction_done(transaction_done), .busy(busy), .error(error),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_source(d_source), .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt)
  );

  // Drives a one-cycle start; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [1:0] t, input logic [AW-1:0] addr, input logic [SW-1:0] sz,
                       input logic [IW-1:0] src, input logic [DW-1:0] wd, input logic [DB-1:0] wm);
    @(negedge clk);
    transaction_type  = t;
    address           = addr;
    size              = sz;
    source            = src;
    write_data        = wd;
    write_mask        = wm;
    start_transaction = 1'b1;
    @(negedge clk);
    start_transaction = 1'b0;
  endtask

  // Waits (bounded) for d_ready, presents one D beat; returns one falling edge after capture.
  task automatic respond(input logic [2:0] op, input logic [IW-1:0] src, input logic den,
                         input logic cor, input logic [DW-1:0] dd);
    for (int k = 0; k < 20 && d_ready !== 1'b1; k++) @(negedge clk);
    d_valid   = 1'b1;
    d_opcode  = op;
    d_source  = src;
    d_denied  = den;
    d_corrupt = cor;
    d_data    = dd;
    @(negedge clk);
    d_valid   = 1'b0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
    checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
    checks++; if ({transaction_done, error} !== 2'b00) begin failures++; $display("FAIL reset_done_err got=%b exp=00", {transaction_done, error}); end
    checks++; if (read_data !== 64'd0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
    checks++;
    if ({a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data} !== '0) begin
      failures++; $display("FAIL reset_a_fields got=%h/%h/%h/%h exp=0", a_opcode, a_address, a_mask, a_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_putfull();
    a_ready = 1'b1;
    issue(2'd1, 32'h0, 3'd3, 4'd0, 64'hABCD_1234_5678_9ABC, 8'h00);
    checks++; if ({busy, a_valid} !== 2'b11) begin failures++; $display("FAIL pf_busy_valid got=%b exp=11", {busy, a_valid}); end
    checks++; if (a_opcode !== 3'd0) begin failures++; $display("FAIL pf_opcode got=%0d exp=0", a_opcode); end
    checks++; if (a_mask !== 8'hFF) begin failures++; $display("FAIL pf_mask got=%h exp=ff", a_mask); end
    checks++; if (a_data !== 64'hABCD_1234_5678_9ABC) begin failures++; $display("FAIL pf_data got=%h exp=abcd123456789abc", a_data); end
    checks++; if ({a_param, a_size} !== {3'd0, 3'd3}) begin failures++; $display("FAIL pf_param_size got=%0d/%0d exp=0/3", a_param, a_size); end
    @(negedge clk);
    checks++; if ({a_valid, d_ready, transaction_done} !== 3'b010) begin failures++; $display("FAIL pf_dwait got=%b exp=010", {a_valid, d_ready, transaction_done}); end
    d_valid = 1'b1; d_opcode = 3'd0; d_source = 4'd0; d_data = 64'd0;
    @(negedge clk);
    d_valid = 1'b0;
    checks++; if ({transaction_done, busy, error} !== 3'b110) begin failures++; $display("FAIL pf_done got=%b exp=110", {transaction_done, busy, error}); end
    @(negedge clk);
    checks++; if ({transaction_done, busy} !== 2'b00) begin failures++; $display("FAIL pf_after_done got=%b exp=00", {transaction_done, busy}); end
  endtask

  task automatic test_get();
    issue(2'd0, 32'h0, 3'd3, 4'd0, 64'h1111_2222_3333_4444, 8'hFF);
    checks++; if (a_opcode !== 3'd4) begin failures++; $display("FAIL get_opcode got=%0d exp=4", a_opcode); end
    checks++; if ({a_mask, a_data} !== {8'hFF, 64'd0}) begin failures++; $display("FAIL get_mask_data got=%h/%h exp=ff/0", a_mask, a_data); end
    respond(3'd1, 4'd0, 1'b0, 1'b0, 64'hABCD_1234_5678_9ABC);
    checks++; if ({transaction_done, error} !== 2'b10) begin failures++; $display("FAIL get_done got=%b exp=10", {transaction_done, error}); end
    checks++; if (read_data !== 64'hABCD_1234_5678_9ABC) begin failures++; $display("FAIL get_rdata got=%h exp=abcd123456789abc", read_data); end
    @(negedge clk);
  endtask

  task automatic test_putpartial();
    a_ready = 1'b0;
    issue(2'd2, 32'h4, 3'd2, 4'd3, 64'h0102_0304_0506_0708, 8'hFF);
    checks++; if ({a_opcode, a_mask} !== {3'd1, 8'hF0}) begin failures++; $display("FAIL pp_op_mask got=%0d/%h exp=1/f0", a_opcode, a_mask); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a_valid, busy, a_opcode, a_mask, a_address, a_source, a_size, a_data} !==
          {1'b1, 1'b1, 3'd1, 8'hF0, 32'h4, 4'd3, 3'd2, 64'h0102_0304_0506_0708}) begin
        failures++; $display("FAIL pp_stall_%0d got=%b%b/%h/%h/%h exp=11/f0/4/0102030405060708", i, a_valid, busy, a_mask, a_address, a_data);
      end
    end
    a_ready = 1'b1;
    respond(3'd0, 4'd3, 1'b0, 1'b0, 64'd0);
    checks++; if ({transaction_done, error} !== 2'b10) begin failures++; $display("FAIL pp_done got=%b exp=10", {transaction_done, error}); end
    issue(2'd2, 32'h0, 3'd2, 4'd3, 64'h0, 8'h3C);
    checks++; if (a_mask !== 8'h0C) begin failures++; $display("FAIL pp_mask_and got=%h exp=0c", a_mask); end
    respond(3'd0, 4'd3, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    issue(2'd0, 32'h5, 3'd1, 4'd0, 64'h0, 8'h00);
    checks++; if (a_mask !== 8'h30) begin failures++; $display("FAIL get_mask_sz1 got=%h exp=30", a_mask); end
    respond(3'd1, 4'd0, 1'b0, 1'b0, 64'h0BAD_F00D_CAFE_BEEF);
    checks++; if (read_data !== 64'h0BAD_F00D_CAFE_BEEF) begin failures++; $display("FAIL get_sz1_rdata got=%h exp=0badf00dcafebeef", read_data); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    issue(2'd0, 32'h0, 3'd3, 4'd0, 64'h0, 8'h00);
    respond(3'd1, 4'd1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
    checks++; if ({transaction_done, error} !== 2'b11) begin failures++; $display("FAIL err_source got=%b exp=11", {transaction_done, error}); end
    checks++; if (read_data !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL err_source_rdata got=%h exp=0123456789abcdef", read_data); end
    @(negedge clk);
    issue(2'd0, 32'h0, 3'd3, 4'd0, 64'h0, 8'h00);
    respond(3'd1, 4'd0, 1'b1, 1'b0, 64'hFEDC_BA98_7654_3210);
    checks++; if ({transaction_done, error} !== 2'b11) begin failures++; $display("FAIL err_denied got=%b exp=11", {transaction_done, error}); end
    @(negedge clk);
    issue(2'd0, 32'h0, 3'd3, 4'd0, 64'h0, 8'h00);
    respond(3'd0, 4'd0, 1'b0, 1'b0, 64'h5555_5555_5555_5555);
    checks++; if ({transaction_done, error} !== 2'b11) begin failures++; $display("FAIL err_opcode got=%b exp=11", {transaction_done, error}); end
    checks++; if (read_data !== 64'hFEDC_BA98_7654_3210) begin failures++; $display("FAIL err_opcode_rdata_hold got=%h exp=fedcba9876543210", read_data); end
    @(negedge clk);
    issue(2'd1, 32'h8, 3'd3, 4'd2, 64'h77, 8'h00);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_hold_until_done got=%b exp=1", error); end
    respond(3'd0, 4'd2, 1'b0, 1'b1, 64'd0);
    checks++; if ({transaction_done, error} !== 2'b11) begin failures++; $display("FAIL err_corrupt got=%b exp=11", {transaction_done, error}); end
    @(negedge clk);
    issue(2'd1, 32'h8, 3'd3, 4'd2, 64'h77, 8'h00);
    respond(3'd0, 4'd2, 1'b0, 1'b0, 64'd0);
    checks++; if ({transaction_done, error} !== 2'b10) begin failures++; $display("FAIL err_clear got=%b exp=10", {transaction_done, error}); end
    @(negedge clk);
    issue(2'd3, 32'h0, 3'd0, 4'd0, 64'h0, 8'h00);
    checks++; if ({transaction_done, error, a_valid, busy} !== 4'b1101) begin failures++; $display("FAIL illegal_type got=%b exp=1101", {transaction_done, error, a_valid, busy}); end
    @(negedge clk);
    checks++; if ({transaction_done, a_valid, busy} !== 3'b000) begin failures++; $display("FAIL illegal_type_after got=%b exp=000", {transaction_done, a_valid, busy}); end
    issue(2'd1, 32'h8, 3'd3, 4'd2, 64'h77, 8'h00);
    respond(3'd0, 4'd2, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    issue(2'd0, 32'h0, 3'd4, 4'd0, 64'h0, 8'h00);
    checks++; if ({transaction_done, error, a_valid} !== 3'b110) begin failures++; $display("FAIL illegal_size got=%b exp=110", {transaction_done, error, a_valid}); end
    @(negedge clk);
  endtask

  task automatic test_start_in_dwait();
    int pulses;
    issue(2'd0, 32'h10, 3'd3, 4'd5, 64'h0, 8'h00);
    @(negedge clk);
    transaction_type = 2'd1; address = 32'h80; start_transaction = 1'b1;
    @(negedge clk);
    start_transaction = 1'b0;
    checks++; if ({a_valid, d_ready, a_address, a_opcode} !== {1'b0, 1'b1, 32'h10, 3'd4}) begin
      failures++; $display("FAIL busy_start_ignored got=%b%b/%h/%0d exp=01/10/4", a_valid, d_ready, a_address, a_opcode);
    end
    respond(3'd1, 4'd5, 1'b0, 1'b0, 64'h00C0_FFEE_0000_1234);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (transaction_done === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL busy_start_pulses got=%0d exp=1", pulses); end
    checks++; if ({busy, a_valid, a_address} !== {1'b0, 1'b0, 32'h10}) begin failures++; $display("FAIL busy_start_idle got=%b%b/%h exp=00/10", busy, a_valid, a_address); end
  endtask

  task automatic test_reset_mid();
    a_ready = 1'b0;
    issue(2'd0, 32'h20, 3'd3, 4'd1, 64'h0, 8'h00);
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", a_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_valid, d_ready, busy, transaction_done, error} !== 5'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=00000", {a_valid, d_ready, busy, transaction_done, error}); end
    checks++; if ({read_data, a_address, a_mask, a_opcode} !== '0) begin failures++; $display("FAIL rstmid_data got=%h/%h/%h exp=0", read_data, a_address, a_mask); end
    @(negedge clk);
    rst = 1'b0;
    a_ready = 1'b1;
    d_valid = 1'b1; d_opcode = 3'd1; d_source = 4'd1; d_data = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({d_ready, transaction_done, busy} !== 3'b000) begin failures++; $display("FAIL stray_d_%0d got=%b exp=000", i, {d_ready, transaction_done, busy}); end
    end
    d_valid = 1'b0;
    checks++; if (read_data !== 64'd0) begin failures++; $display("FAIL stray_d_rdata got=%h exp=0", read_data); end
    issue(2'd0, 32'h28, 3'd3, 4'd1, 64'h0, 8'h00);
    respond(3'd1, 4'd1, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0);
    checks++; if ({transaction_done, error, read_data} !== {1'b1, 1'b0, 64'h1357_9BDF_2468_ACE0}) begin
      failures++; $display("FAIL rstmid_next got=%b%b/%h exp=10/13579bdf2468ace0", transaction_done, error, read_data);
    end
    @(negedge clk);
  endtask

`ifdef TL_ADAPTER_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    issue(2'd0, 32'h30, 3'd3, 4'd2, 64'h0, 8'h00);
    @(negedge clk);
    k = 0;
    while (transaction_done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 8) begin failures++; $display("FAIL timeout_latency got=%0d exp=8", k); end
    checks++; if ({transaction_done, error, read_data} !== {1'b1, 1'b1, 64'h1357_9BDF_2468_ACE0}) begin
      failures++; $display("FAIL timeout_status got=%b%b/%h exp=11/13579bdf2468ace0", transaction_done, error, read_data);
    end
    @(negedge clk);
    d_valid = 1'b1; d_opcode = 3'd1; d_source = 4'd2; d_data = 64'h1;
    @(negedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    checks++; if ({transaction_done, busy, read_data} !== {1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0}) begin
      failures++; $display("FAIL timeout_stray got=%b%b/%h exp=00/13579bdf2468ace0", transaction_done, busy, read_data);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_transaction = 1'b0; transaction_type = 2'd0; address = '0; size = '0;
    source = '0; write_data = '0; write_mask = '0; a_ready = 1'b1; d_valid = 1'b0;
    d_opcode = '0; d_source = '0; d_data = '0; d_denied = 1'b0; d_corrupt = 1'b0;
    test_reset();
    test_putfull();
    test_get();
    test_putpartial();
    test_errors();
    test_start_in_dwait();
    test_reset_mid();
`ifdef TL_ADAPTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_l1_adapter.md
# tl_l1_adapter

- Converts one L1-side transaction request (Get, PutFullData, PutPartialData) into a single-beat TileLink-UL A-channel message.
- Waits for the matching D-channel response, then reports completion, read data and error status.
- One instance per L1 port; it sits between the testbench/core request interface and the TileLink crossbar.
- At most one transaction is in flight per instance.

## Interface

Parameters:

- ADDR_BITS, default `TL_ADDR_BITS: address width.
- SIZE_BITS, default `TL_SIZE_BITS: size field width (log2 bytes).
- SOURCE_BITS, default `TL_SOURCE_BITS: source ID width.
- DATA_BYTES, default `TL_DATA_BYTES: beat width in bytes (power of two, ≥2).
- TIMEOUT_CYCLES, default 256: D-wait limit (used only with TL_ADAPTER_TIMEOUT_EN).

Ports:

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start_transaction  in  1  one-cycle start pulse.
- transaction_type  in  2  0=Get, 1=PutFull, 2=PutPartial, 3=illegal.
- address / size / source  in  ADDR_BITS / SIZE_BITS / SOURCE_BITS  request fields.
- write_data / write_mask  in  DATA_BYTES*8 / DATA_BYTES  Put payload and mask.
- read_data  out  DATA_BYTES*8  last AccessAckData payload.
- transaction_done  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted start until the done pulse, inclusive.
- error  out  1  status of the last completed transaction.
- a_valid  out  1  A-channel valid.
- a_ready  in  1  A-channel ready.
- a_opcode / a_param  out  3 / 3  A-channel opcode and param.
- a_size / a_source / a_address  out  SIZE_BITS / SOURCE_BITS / ADDR_BITS  A-channel fields.
- a_mask / a_data  out  DATA_BYTES / DATA_BYTES*8  A-channel mask and data.
- d_valid  in  1  D-channel valid.
- d_ready  out  1  D-channel ready.
- d_opcode / d_source / d_data  in  3 / SOURCE_BITS / DATA_BYTES*8  D-channel fields.
- d_denied / d_corrupt  in  1 / 1  D-channel error flags.

## Operation

FSM states:

- IDLE
  - Sample start_transaction. If it is high, latch every request field.
  - Legal request: go to A_REQ.
  - Type 3, or size > log2(DATA_BYTES): go to DONE with error=1. No A message is issued.
- A_REQ
  - a_valid=1 with fields held stable from the latch.
  - On a_valid&&a_ready, go to D_WAIT.
- D_WAIT
  - d_ready=1.
  - On d_valid, capture the response and go to DONE.
- DONE
  - transaction_done=1 for this one cycle, then return to IDLE.

A-channel encoding:

- Opcodes: Get=4, PutFull=0, PutPartial=1.
- a_param=0.
- a_data = write_data for Puts, 0 for Get.
- a_mask, Get and PutFull: (2^(2^size))−1 shifted left by address[log2(DATA_BYTES)−1:0] rounded down to a 2^size alignment. When size = log2(DATA_BYTES), all ones.
- a_mask, PutPartial: write_mask ANDed with that same size mask.

D-channel checking and outputs:

- The expected opcode is AccessAckData (1) for Get and AccessAck (0) for Puts.
- error=1 if d_opcode differs from the expected value, d_source differs from the latched source, d_denied is set, or d_corrupt is set. Otherwise error=0.
- read_data updates only on an AccessAckData response, even an erroneous one. It holds its value otherwise.
- error is valid from the DONE cycle and holds until the next DONE.

Boundary conditions:

- start_transaction while busy: ignored, no queuing.
- d_valid outside D_WAIT: d_ready=0, no state change.
- rst mid-transaction: a_valid, d_ready and busy drop immediately (asynchronously); the FSM returns to IDLE. A D response for the aborted request is ignored.

## Timing

- Reset values: every output is 0, including read_data, error and the a_* fields. FSM is in IDLE.
- Start pulse at edge N (IDLE): busy=1 and a_valid=1 after edge N.
- With a_ready held high: A handshake at edge N+1. D_WAIT from N+1.
- With d_valid present at edge N+2: transaction_done is high during cycle N+2..N+3. Minimum latency from start to done is 3 cycles.
- Illegal request: done is high in the cycle after the start edge (latency 1).
- a_* fields change only in IDLE. They are never modified while a_valid=1 and the handshake has not completed.
- busy falls in the same edge that ends the done pulse, so a new start is accepted one cycle after done.

## Configuration

Macro: TL_ADAPTER_TIMEOUT_EN.

- Defined:
  - A counter clears on entry to D_WAIT and increments on each D_WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no d_valid, the FSM goes to DONE with error=1 and read_data unchanged.
  - A later stray response is ignored.
- Undefined:
  - No counter is built. D_WAIT waits indefinitely.

## Test plan

1. PutFull to address 0x0, size=3, data 0xABCD_1234_5678_9ABC, a_ready=1, AccessAck with source 0.
   - a_opcode=0, a_mask=0xFF.
   - Done 3 cycles after start, error=0.
2. Get from 0x0, size=3, AccessAckData with data 0xABCD_1234_5678_9ABC.
   - a_opcode=4.
   - read_data=0xABCD_1234_5678_9ABC on the done cycle, error=0.
3. PutPartial to address 0x4, size=2, write_mask=0xFF.
   - a_mask=0xF0.
   - With a_ready held low for 5 cycles, a_valid and all fields stay stable, and busy stays high.
4. Error responses.
   - Get answered with d_source=1 while the latched source is 0: error=1 on done.
   - Get answered with d_denied=1: error=1 on done.
   - Type 3 request: done 1 cycle after start, error=1, a_valid never asserted.
5. Start pulse during D_WAIT.
   - Ignored; exactly one done pulse.
6. rst asserted mid-transaction.
   - rst asserted while a_valid=1: all outputs are 0 immediately.
   - Next Get completes normally.
7. With TL_ADAPTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, no D response.
   - Done with error=1 eight cycles after the A handshake.
